prince_job_arbiter: RTL and testbench
=====================================

// Module: prince_job_arbiter
// PURPOSE
// - Shares one masked PRINCE core and its round controller among NREQ requesters.
// - Selects one request at a time, round-robin.
// - Handshakes with the mask PRNG so fresh randomness is loaded before every job.
// - Sequences the round controller's reset/enable/direction inputs.
// - Returns a tagged completion to the granted requester.
// - Sits between the requester ports and the round-controller/datapath pair.
//   Data muxing is external and steered by grant_id.
// PARAMETERS
// - NREQ      4   number of requesters, 2..8
// - IDW       3   width of grant_id/rsp_id; must satisfy 2**IDW >= NREQ
// - RUN_MAX   16  watchdog limit: max RUN cycles before abort (core needs 13)
// PORTS
// - clk         in   1     clock
// - rst         in   1     synchronous reset, active-high
// - req_valid   in   NREQ  request pending, one bit per requester
// - req_enc     in   NREQ  per requester: 1 = encrypt, 0 = decrypt
// - req_ready   out  NREQ  one-hot accept pulse to the granted requester
// - grant_id    out  IDW   index of the active requester; steers the external data mux
// - rnd_req     out  1     request a fresh mask/randomness load
// - rnd_ack     in   1     PRNG has loaded fresh masks
// - core_rst    out  1     reset to the round controller
// - core_en     out  1     enable to the round controller
// - core_enc    out  1     direction to the round controller
// - core_done   in   1     round controller reports the final round
// - rsp_valid   out  1     result ready for requester rsp_id
// - rsp_id      out  IDW   requester that owns the result
// - rsp_ready   in   1     result consumed
// - err         out  1     sticky watchdog abort flag; cleared only by rst
// BEHAVIOUR
// - Reset values: state IDLE, rr_ptr 0, req_ready 0, grant_id 0, rnd_req 0,
//   core_rst 1, core_en 0, core_enc 0, rsp_valid 0, rsp_id 0, err 0.
// - Reset mid-job abandons the job silently; no response is issued.
// - FSM states: IDLE, LOAD, RUN, RESP.
// - IDLE: core_rst=1, core_en=0.
//   - If any req_valid: pick the first set bit scanning from rr_ptr upward, mod NREQ.
//   - Register the pick into grant_id; latch core_enc = req_enc[pick].
//   - Pulse req_ready[pick] for exactly 1 cycle.
//   - Go to LOAD.
// - LOAD: hold rnd_req=1 and core_rst=1 until rnd_ack is sampled high.
//   - On that cycle: drop rnd_req; set run_cnt=0; go to RUN.
//   - Wait is unbounded; the watchdog does not apply here.
// - RUN: core_rst=0, core_en=1, run_cnt increments each cycle.
//   - core_done=1 -> core_en=0 combinationally; go to RESP. rsp_valid=1 from the next cycle.
//   - run_cnt == RUN_MAX-1 without done -> set err=1; go to IDLE.
//     No response is issued and rr_ptr still advances.
// - RESP: rsp_valid=1, rsp_id=grant_id, core_en=0, core_rst=0.
//   - Holding core_rst=0 keeps the datapath result stable.
//   - rsp_ready high -> rsp_valid drops the next cycle; rr_ptr = grant_id+1 mod NREQ; go to IDLE.
//   - Back-pressure (rsp_ready low) stalls indefinitely.
//   - New requests are never granted while in LOAD/RUN/RESP.
// - Latency: req_valid -> req_ready is 1 cycle from IDLE.
//   - rnd_ack -> rsp_valid is 14 cycles with a nominal core.
// - Priority: a single requester may win back-to-back only if no other bit is set.
// - Ordering and protocol:
//   - req_valid deassertion after grant has no effect on the running job.
//   - req_enc is sampled only on the grant cycle.
//   - rnd_ack outside LOAD is ignored.
//   - core_done outside RUN is ignored.
// - Fairness bound: every asserted requester is served within NREQ jobs.
// STRUCTURE
// - Shared package: state encoding localparams (IDLE/LOAD/RUN/RESP), PRINCE_ROUNDS=13, default RUN_MAX.
// - One sub-module: prince_rr_pick. Combinational round-robin priority encoder
//   (req vector, ptr -> onehot, idx, any).
// - FSM, run_cnt, rr_ptr and err are kept in this module.
// TESTING
// - Single job: req_valid=4'b0100, enc=1; rnd_ack after 3 cycles; core model asserts done on the 13th RUN cycle.
//   -> req_ready=4'b0100, core_enc=1, rsp_valid with rsp_id=2, rr_ptr=3.
// - Contention: req_valid=4'b1111 held, rsp_ready=1.
//   -> grant sequence 0,1,2,3,0; no id repeats before all are served.
// - Back-pressure: rsp_ready low for 20 cycles while req_valid=4'b0011.
//   -> rsp_valid/rsp_id stable, core_en=0, req_ready stays 0; after ready, next grant goes to id 1.
// - Watchdog: core_done tied 0.
//   -> after 16 RUN cycles err=1, FSM in IDLE, no rsp_valid; next request still served.
// - Reset mid-RUN: assert rst at RUN cycle 5.
//   -> next cycle all outputs at reset values, core_rst=1, err=0, no response.
// - Decrypt plus late randomness: req_enc=0 on id 3; rnd_ack delayed 50 cycles.
//   -> core_rst held 1 and core_en 0 throughout LOAD; core_enc=0 in RUN.

Source files
------------

// File: rtl/prince_job_arbiter_pkg.sv
// Shared types and constants for the PRINCE job arbiter.
package prince_job_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam int PRINCE_ROUNDS = 13;
  // Three cycles of slack beyond the nominal round count before the watchdog fires.
  localparam int RUN_MAX_DEF   = PRINCE_ROUNDS + 3;

endpackage

// File: rtl/prince_job_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or after ptr_i, wrapping.
module prince_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  function automatic int wrap_idx(input int p, input int k);
    return (p + k) % NREQ;
  endfunction

  // Scan from the farthest offset down so the nearest request is the last to write.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (|(req_i & (NREQ'(1) << wrap_idx(int'(ptr_i), k)))) begin
        onehot_o = NREQ'(1) << wrap_idx(int'(ptr_i), k);
        idx_o    = IDW'(wrap_idx(int'(ptr_i), k));
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prince_job_arbiter.sv
// Round-robin arbiter sharing one masked PRINCE core among NREQ requesters.
// state | meaning: IDLE pick next job | LOAD wait PRNG masks | RUN core rounds | RESP hold result
module prince_job_arbiter
  import prince_job_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 3,
  parameter int RUN_MAX = RUN_MAX_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid_i,
  input  logic [NREQ-1:0] req_enc_i,
  output logic [NREQ-1:0] req_ready_o,
  output logic [IDW-1:0]  grant_id_o,
  output logic            rnd_req_o,
  input  logic            rnd_ack_i,
  output logic            core_rst_o,
  output logic            core_en_o,
  output logic            core_enc_o,
  input  logic            core_done_i,
  output logic            rsp_valid_o,
  output logic [IDW-1:0]  rsp_id_o,
  input  logic            rsp_ready_i,
  output logic            err_o
);

  localparam int RCW = $clog2(RUN_MAX);

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;
  logic            core_enc_q, core_enc_d;
  logic [NREQ-1:0] req_ready_q, req_ready_d;
  logic [RCW-1:0]  run_cnt_q, run_cnt_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] pick_oh;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;
  logic [IDW-1:0]  ptr_next;

  prince_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_i    (req_valid_i),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  assign ptr_next = (grant_id_q == IDW'(NREQ - 1)) ? '0 : grant_id_q + IDW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      core_enc_q  <= 1'b0;
      req_ready_q <= '0;
      run_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      core_enc_q  <= core_enc_d;
      req_ready_q <= req_ready_d;
      run_cnt_q   <= run_cnt_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    core_enc_d  = core_enc_q;
    req_ready_d = '0;
    run_cnt_d   = run_cnt_q;
    err_d       = err_q;
    rnd_req_o   = 1'b0;
    core_rst_o  = 1'b1;
    core_en_o   = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_id_d  = pick_idx;
          core_enc_d  = |(req_enc_i & pick_oh);
          req_ready_d = pick_oh;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        rnd_req_o = 1'b1;
        if (rnd_ack_i) begin
          run_cnt_d = '0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        core_rst_o = 1'b0;
        core_en_o  = !core_done_i;
        run_cnt_d  = run_cnt_q + RCW'(1);
        if (core_done_i) begin
          state_d = ST_RESP;
        end else if (run_cnt_q == RCW'(RUN_MAX - 1)) begin
          // Aborted job gets no response but still gives up its turn.
          err_d    = 1'b1;
          rr_ptr_d = ptr_next;
          state_d  = ST_IDLE;
        end
      end
      ST_RESP: begin
        core_rst_o  = 1'b0;
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          rr_ptr_d = ptr_next;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready_o = req_ready_q;
  assign grant_id_o  = grant_id_q;
  assign core_enc_o  = core_enc_q;
  assign rsp_id_o    = rsp_valid_o ? grant_id_q : '0;
  assign err_o       = err_q;

endmodule

// File: tb/tb_prince_job_arbiter.sv
// Directed, table-driven bench for prince_job_arbiter with a 13-round core model.
module tb_prince_job_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_valid, req_enc, req_ready;
  logic [2:0] grant_id, rsp_id;
  logic       rnd_req, rnd_ack, core_rst, core_en, core_enc, core_done;
  logic       rsp_valid, rsp_ready, err;

  logic       core_ok;
  int         core_cnt;
  int         checks = 0;
  int         failures = 0;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] enc;
    int         g;
    logic       e;
  } vec_t;
  vec_t tbl[10];

  prince_job_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_enc_i   (req_enc),
    .req_ready_o (req_ready),
    .grant_id_o  (grant_id),
    .rnd_req_o   (rnd_req),
    .rnd_ack_i   (rnd_ack),
    .core_rst_o  (core_rst),
    .core_en_o   (core_en),
    .core_enc_o  (core_enc),
    .core_done_i (core_done),
    .rsp_valid_o (rsp_valid),
    .rsp_id_o    (rsp_id),
    .rsp_ready_i (rsp_ready),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  // Core model: done on the 13th enabled cycle out of reset.
  always @(posedge clk) begin
    if (core_rst) core_cnt <= 0;
    else if (core_en) core_cnt <= core_cnt + 1;
  end
  assign core_done = core_ok && !core_rst && (core_cnt == 12);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " req_ready"}, 32'(req_ready), 0);
    chk({tag, " grant_id"},  32'(grant_id), 0);
    chk({tag, " rnd_req"},   32'(rnd_req), 0);
    chk({tag, " core_rst"},  32'(core_rst), 1);
    chk({tag, " core_en"},   32'(core_en), 0);
    chk({tag, " core_enc"},  32'(core_enc), 0);
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, " rsp_id"},    32'(rsp_id), 0);
    chk({tag, " err"},       32'(err), 0);
    chk({tag, " rr_ptr"},    32'(dut.rr_ptr_q), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; req_enc = '0; rnd_ack = 1'b0; rsp_ready = 1'b0; core_ok = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One full job from IDLE: grant, LOAD for ack_dly cycles, RUN, RESP with bp stall cycles.
  task automatic run_job(input string tag, input logic [3:0] v, input logic [3:0] e,
                         input int ack_dly, input int exp_g, input logic exp_e,
                         input int bp, input bit keep);
    int lat;
    req_valid = v; req_enc = e; rsp_ready = (bp == 0);
    tick();
    chk({tag, " req_ready"}, 32'(req_ready), 32'(4'b0001 << exp_g));
    chk({tag, " grant_id"},  32'(grant_id), 32'(exp_g));
    chk({tag, " core_enc"},  32'(core_enc), 32'(exp_e));
    chk({tag, " rnd_req"},   32'(rnd_req), 1);
    if (!keep) req_valid = '0;
    req_enc = ~e;
    for (int i = 0; i < ack_dly; i++) begin
      tick();
      chk({tag, " load hold"}, 32'({rnd_req, core_rst, core_en, req_ready}), 32'(7'b110_0000));
    end
    rnd_ack = 1'b1;
    tick();
    rnd_ack = 1'b0;
    chk({tag, " run ctl"}, 32'({core_rst, core_en, rnd_req, req_ready}), 32'(7'b010_0000));
    chk({tag, " run enc"}, 32'(core_enc), 32'(exp_e));
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 14);
    chk({tag, " rsp_id"},  32'(rsp_id), 32'(exp_g));
    for (int i = 0; i < bp; i++) begin
      tick();
      chk({tag, " bp hold"}, 32'({rsp_valid, rsp_id, core_en, core_rst, req_ready}),
          32'({1'b1, 3'(exp_g), 1'b0, 1'b0, 4'b0000}));
    end
    rsp_ready = 1'b1;
    tick();
    chk({tag, " rsp drop"}, 32'(rsp_valid), 0);
    chk({tag, " rr_ptr"},   32'(dut.rr_ptr_q), 32'((exp_g + 1) % 4));
  endtask

  initial begin
    int n;
    bit seen;

    tbl[0] = '{4'b1111, 4'b0101, 0, 1'b1};
    tbl[1] = '{4'b1111, 4'b0101, 1, 1'b0};
    tbl[2] = '{4'b1111, 4'b0101, 2, 1'b1};
    tbl[3] = '{4'b1111, 4'b0101, 3, 1'b0};
    tbl[4] = '{4'b1111, 4'b0101, 0, 1'b1};
    tbl[5] = '{4'b0001, 4'b0001, 0, 1'b1};
    tbl[6] = '{4'b0001, 4'b0001, 0, 1'b1};
    tbl[7] = '{4'b1001, 4'b1000, 3, 1'b1};
    tbl[8] = '{4'b0110, 4'b0000, 1, 1'b0};
    tbl[9] = '{4'b0010, 4'b0010, 1, 1'b1};

    core_cnt = 0;
    rst = 1'b1;
    req_valid = '0; req_enc = '0; rnd_ack = 1'b0; rsp_ready = 1'b0; core_ok = 1'b1;
    tick();
    chk_reset_vals("reset");
    rst = 1'b0;

    // Stray rnd_ack in IDLE must not start anything.
    rnd_ack = 1'b1;
    tick();
    rnd_ack = 1'b0;
    tick();
    chk("stray ack", 32'({rnd_req, core_rst, req_ready}), 32'(6'b01_0000));

    run_job("single", 4'b0100, 4'b0100, 3, 2, 1'b1, 0, 1'b0);
    chk("single rr_ptr3", 32'(dut.rr_ptr_q), 3);

    do_reset();
    for (int i = 0; i < 10; i++)
      run_job($sformatf("vec%0d", i), tbl[i].valid, tbl[i].enc, 0, tbl[i].g, tbl[i].e, 0, 1'b0);

    do_reset();
    run_job("bp", 4'b0011, 4'b0000, 0, 0, 1'b0, 20, 1'b1);
    run_job("bp next", 4'b0011, 4'b0000, 0, 1, 1'b0, 0, 1'b0);

    // Watchdog: core never reports done.
    core_ok = 1'b0;
    req_valid = 4'b0001;
    tick();
    chk("wd grant", 32'(grant_id), 0);
    req_valid = '0;
    rnd_ack = 1'b1;
    tick();
    rnd_ack = 1'b0;
    n = 0; seen = 1'b0;
    while (core_en && n < 40) begin
      n++;
      if (rsp_valid) seen = 1'b1;
      tick();
    end
    chk("wd run cycles", 32'(n), 16);
    chk("wd err", 32'(err), 1);
    chk("wd no rsp", 32'({seen, rsp_valid}), 0);
    chk("wd idle", 32'({core_rst, rnd_req, core_en}), 32'(3'b100));
    chk("wd rr_ptr", 32'(dut.rr_ptr_q), 1);
    core_ok = 1'b1;
    run_job("post wd", 4'b0100, 4'b0100, 0, 2, 1'b1, 0, 1'b0);
    chk("err sticky", 32'(err), 1);

    // Reset in the 5th RUN cycle abandons the job.
    req_valid = 4'b0010; req_enc = 4'b0010;
    tick();
    chk("mid grant", 32'(grant_id), 1);
    req_valid = '0;
    rnd_ack = 1'b1;
    tick();
    rnd_ack = 1'b0;
    repeat (4) tick();
    chk("mid run", 32'({core_en, core_enc}), 32'(2'b11));
    rst = 1'b1;
    tick();
    chk_reset_vals("mid reset");
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    chk("mid no rsp", 32'(seen), 0);

    do_reset();
    run_job("late dec", 4'b1000, 4'b0000, 50, 3, 1'b0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
